// File: rtl/alu16_sequencer.sv
// Runs 16-bit add/sub/inc/pass through an external 8-bit arithmetic unit in two
// passes (low byte, then high byte) and returns a registered result with C/V/Z/N.
module alu16_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic [1:0]  in_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_s,
  input  logic [7:0]  alu_out,
  input  logic        alu_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_res,
  output logic        out_c,
  output logic        out_v,
  output logic        out_z,
  output logic        out_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      state_reg;
  logic [15:0] a_reg;
  logic [15:0] beff_reg;
  logic [7:0]  res_lo_reg;

  logic [15:0] beff_next;
  logic        cin0_next;
  logic [15:0] res_full;

  // Every op is reduced to A + Beff + cin0 so both slices share one datapath.
  always_comb begin
    beff_next = 16'h0000;
    cin0_next = 1'b0;
    case (in_op)
      2'b00:   beff_next = in_b;
      2'b01: begin
        beff_next = ~in_b;
        cin0_next = 1'b1;
      end
      2'b10:   beff_next = 16'h0001;
      default: beff_next = 16'h0000;
    endcase
  end

  assign res_full = {alu_out, res_lo_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      in_ready   <= 1'b1;
      a_reg      <= 16'h0000;
      beff_reg   <= 16'h0000;
      res_lo_reg <= 8'h00;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_s      <= 2'b11;
      out_valid  <= 1'b0;
      out_res    <= 16'h0000;
      out_c      <= 1'b0;
      out_v      <= 1'b0;
      out_z      <= 1'b0;
      out_n      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            beff_reg <= beff_next;
            in_ready <= 1'b0;
            // Carry-in of 1 is expressed as S=01 with inverted B: A + ~~b + 1.
            alu_a    <= in_a[7:0];
            alu_s    <= cin0_next ? 2'b01 : 2'b00;
            alu_b    <= cin0_next ? ~beff_next[7:0] : beff_next[7:0];
            state_reg <= LO;
          end
        end
        LO: begin
          res_lo_reg <= alu_out;
          alu_a      <= a_reg[15:8];
          alu_s      <= alu_cout ? 2'b01 : 2'b00;
          alu_b      <= alu_cout ? ~beff_reg[15:8] : beff_reg[15:8];
          state_reg  <= HI;
        end
        HI: begin
          out_res   <= res_full;
          out_c     <= alu_cout;
          out_v     <= (a_reg[15] == beff_reg[15]) & (alu_out[7] != a_reg[15]);
          out_z     <= (res_full == 16'h0000);
          out_n     <= alu_out[7];
          out_valid <= 1'b1;
          alu_a     <= 8'h00;
          alu_b     <= 8'h00;
          alu_s     <= 2'b11;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench for alu16_sequencer: behavioural 8-bit unit plus a
// 16-bit arithmetic reference model computed with plain integer math.
module tb_alu16_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [1:0]  in_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [1:0]  alu_s;
  logic [7:0]  alu_out;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic        out_c, out_v, out_z, out_n;

  int checks = 0;
  int fails  = 0;

  logic [1:0] lo_s, hi_s;
  logic [7:0] lo_b, hi_b;

  alu16_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n)
  );

  always #5 clk = ~clk;

  // 8-bit arithmetic unit
  logic [8:0] unit_sum;
  always_comb begin
    unit_sum = 9'h000;
    case (alu_s)
      2'b00:   unit_sum = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   unit_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      2'b10:   unit_sum = {1'b0, alu_a} + 9'd1;
      default: unit_sum = {1'b0, alu_a};
    endcase
  end
  assign alu_out  = unit_sum[7:0];
  assign alu_cout = unit_sum[8];

  // Reference: 17-bit unsigned sum for carry, signed integer result for overflow.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    logic [16:0] full;
    int sa, sb, sr;
    logic [15:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      2'b00: begin full = {1'b0, a} + {1'b0, b};        sr = sa + sb; end
      2'b01: begin full = {1'b0, a} + {1'b0, ~b} + 17'd1; sr = sa - sb; end
      2'b10: begin full = {1'b0, a} + 17'd1;            sr = sa + 1;  end
      default: begin full = {1'b0, a};                  sr = sa;      end
    endcase
    r = full[15:0];
    v = (sr > 32767) || (sr < -32768);
    return {r, full[16], v, (r == 16'h0000), r[15]};
  endfunction

  // Issues one op, records LO/HI unit drive, returns at the negedge where out_valid is seen.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op, input logic rdy);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = rdy;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_op = 2'($urandom);
    lo_s = alu_s; lo_b = alu_b;
    @(negedge clk);
    hi_s = alu_s; hi_b = alu_b;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    checks++;
    if (!out_valid || n != 1) begin
      fails++;
      $display("FAIL latency: out_valid=%b after %0d cycles in HI, required 1 after 1", out_valid, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 16'h0; in_b = 16'h0; in_op = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_res, out_c, out_v, out_z, out_n, alu_a, alu_b, alu_s}
        !== {1'b1, 1'b0, 16'h0, 4'b0, 8'h0, 8'h0, 2'b11}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h flags=%b alu=%h/%h/%b required 1 0 0000 0000 00/00/11",
               in_ready, out_valid, out_res, {out_c, out_v, out_z, out_n}, alu_a, alu_b, alu_s);
    end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  localparam logic [53:0] DIR [0:6] = '{
    {16'h00FF, 16'h0001, 2'b00, 16'h0100, 4'b0000},
    {16'h0100, 16'h0001, 2'b01, 16'h00FF, 4'b1000},
    {16'h0000, 16'h0001, 2'b01, 16'hFFFF, 4'b0001},
    {16'h7FFF, 16'h0001, 2'b00, 16'h8000, 4'b0101},
    {16'h8000, 16'h0001, 2'b01, 16'h7FFF, 4'b1100},
    {16'hFFFF, 16'h0000, 2'b10, 16'h0000, 4'b1010},
    {16'h1234, 16'hBEEF, 2'b11, 16'h1234, 4'b0000}
  };

  task automatic test_directed;
    logic [53:0] e;
    for (int i = 0; i < 7; i++) begin
      e = DIR[i];
      do_op(e[53:38], e[37:22], e[21:20], 1'b1);
      checks++;
      if ({out_res, out_c, out_v, out_z, out_n} !== e[19:0]) begin
        fails++;
        $display("FAIL directed_%0d: res=%h cvzn=%b required res=%h cvzn=%b",
                 i, out_res, {out_c, out_v, out_z, out_n}, e[19:4], e[3:0]);
      end
      $display("directed %0d: a=%h b=%h op=%0d -> res=%h cvzn=%b", i, e[53:38], e[37:22], e[21:20],
               out_res, {out_c, out_v, out_z, out_n});
      if (i == 0) begin
        checks++;
        if ({lo_s, lo_b, hi_s, hi_b} !== {2'b00, 8'h01, 2'b01, 8'hFF}) begin
          fails++;
          $display("FAIL slice_drive: lo s=%b b=%h hi s=%b b=%h required lo 00/01 hi 01/FF",
                   lo_s, lo_b, hi_s, hi_b);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b;
    logic [1:0] op;
    logic [19:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
      if (i % 5 == 0) a = (i % 10 == 0) ? 16'h7FFF : 16'h8000;
      exp = model(a, b, op);
      do_op(a, b, op, 1'b1);
      checks++;
      if ({out_res, out_c, out_v, out_z, out_n} !== exp) begin
        fails++;
        $display("FAIL random_%0d: a=%h b=%h op=%0d res=%h cvzn=%b required res=%h cvzn=%b",
                 i, a, b, op, out_res, {out_c, out_v, out_z, out_n}, exp[19:4], exp[3:0]);
      end
      $display("random %0d: a=%h b=%h op=%0d -> res=%h cvzn=%b", i, a, b, op,
               out_res, {out_c, out_v, out_z, out_n});
    end
  endtask

  task automatic test_backpressure;
    logic [19:0] exp;
    exp = model(16'h1357, 16'hF0F0, 2'b01);
    do_op(16'h1357, 16'hF0F0, 2'b01, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({out_valid, in_ready, out_res, out_c, out_v, out_z, out_n} !== {2'b10, exp}) begin
        fails++;
        $display("FAIL stall_%0d: vld=%b rdy=%b res=%h cvzn=%b required 1 0 %h %b",
                 i, out_valid, in_ready, out_res, {out_c, out_v, out_z, out_n}, exp[19:4], exp[3:0]);
      end
      in_valid = (i % 2 == 0);
      in_a = 16'($urandom); in_b = 16'($urandom); in_op = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL stall_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    $display("backpressure: held res=%h for 10 cycles, released", exp[19:4]);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_a = 16'hAAAA; in_b = 16'h5555; in_op = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_res, out_c, out_v, out_z, out_n, alu_a, alu_b, alu_s}
        !== {1'b1, 1'b0, 16'h0, 4'b0, 8'h0, 8'h0, 2'b11}) begin
      fails++;
      $display("FAIL reset_mid: rdy=%b vld=%b res=%h flags=%b alu=%h/%h/%b required 1 0 0000 0000 00/00/11",
               in_ready, out_valid, out_res, {out_c, out_v, out_z, out_n}, alu_a, alu_b, alu_s);
    end
    do_op(16'h0002, 16'h0003, 2'b00, 1'b1);
    checks++;
    if ({out_res, out_c, out_v, out_z, out_n} !== {16'h0005, 4'b0000}) begin
      fails++;
      $display("FAIL after_reset_add: res=%h cvzn=%b required 0005 0000", out_res, {out_c, out_v, out_z, out_n});
    end
    $display("reset_mid: aborted, then 2+3 -> %h", out_res);
  endtask

  task automatic test_back_to_back;
    logic [19:0] q[$];
    logic [19:0] exp;
    int last_cyc;
    last_cyc = -1;
    out_ready = 1'b1;
    in_a = 16'($urandom); in_b = 16'($urandom); in_op = 2'($urandom);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (cyc >= 40) in_valid = 1'b0;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_spurious: out_valid with no pending op at cycle %0d", cyc);
        end else begin
          exp = q.pop_front();
          if ({out_res, out_c, out_v, out_z, out_n} !== exp) begin
            fails++;
            $display("FAIL b2b_result: res=%h cvzn=%b required %h %b",
                     out_res, {out_c, out_v, out_z, out_n}, exp[19:4], exp[3:0]);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 4) begin
            fails++;
            $display("FAIL b2b_interval: %0d cycles required 4", cyc - last_cyc);
          end
        end
        $display("b2b: cycle %0d res=%h", cyc, out_res);
        last_cyc = cyc;
      end
      if (in_ready && in_valid) begin
        q.push_back(model(in_a, in_b, in_op));
        @(posedge clk);
        #1;
        in_a = 16'($urandom); in_b = 16'($urandom); in_op = 2'($urandom);
      end
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL b2b_drain: %0d results outstanding required 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
